// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b memory access unit.
package lc3b_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2,
        S_ERR    = 2'd3
    } mem_state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    function automatic logic [1:0] byte_enables(input logic is_byte, input logic addr0);
        if (!is_byte)
            return BE_WORD;
        return addr0 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/lc3b_ld_format.sv
// Load data formatting: word passthrough or byte select with sign extension.
module lc3b_ld_format (
    input  logic [15:0] rdata,
    input  logic        is_byte,
    input  logic        addr0,
    output logic [15:0] data
);
    logic [7:0] sel;

    always_comb begin
        sel = addr0 ? rdata[15:8] : rdata[7:0];
        if (is_byte)
            data = {{8{sel[7]}}, sel};
        else
            data = rdata;
    end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// Multi-cycle load/store unit for the LC-3b datapath; also drives the
// register-file write port when a load completes.
module lc3b_mem_ctrl
    import lc3b_mem_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_ldreg,
    input  logic [2:0]  req_dr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_r,
    output logic [15:0] data,
    output logic        ld_reg,
    output logic [2:0]  dr,
    output logic        done,
    output logic        err
);
    // state    | meaning
    // S_IDLE   | ready for a request, latches it on req_valid
    // S_ACCESS | memory port active, waiting for mem_r or timeout
    // S_WB     | one-cycle completion, register-file write for loads
    // S_ERR    | one-cycle error completion (unaligned or timeout)

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT) - 16'd1;

    mem_state_t  state_q, state_d;
    logic        we_q, byte_q, ldreg_q;
    logic [15:0] addr_q, wdata_q, rdata_q, wait_cnt;
    logic [2:0]  dr_q;
    logic [15:0] fmt_data;
    logic        timeout;

    lc3b_ld_format u_fmt (
        .rdata   (rdata_q),
        .is_byte (byte_q),
        .addr0   (addr_q[0]),
        .data    (fmt_data)
    );

    assign timeout = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            ldreg_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dr_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                we_q    <= req_we;
                byte_q  <= req_byte;
                ldreg_q <= req_ldreg;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                dr_q    <= req_dr;
            end
            if (state_q == S_ACCESS) begin
                wait_cnt <= wait_cnt + 16'd1;
                if (mem_r)
                    rdata_q <= mem_rdata;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        data      = '0;
        ld_reg    = 1'b0;
        dr        = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = (!req_byte && req_addr[0]) ? S_ERR : S_ACCESS;
            end
            S_ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_be    = byte_enables(byte_q, addr_q[0]);
                mem_addr  = {addr_q[15:1], 1'b0};
                mem_wdata = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
                if (mem_r)
                    state_d = S_WB;
                else if (timeout)
                    state_d = S_ERR;
            end
            S_WB: begin
                done    = 1'b1;
                ld_reg  = !we_q && ldreg_q;
                data    = we_q ? 16'h0000 : fmt_data;
                dr      = dr_q;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Directed, table-driven bench for lc3b_mem_ctrl (built with MAX_WAIT=4).
module tb_lc3b_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_byte, req_ldreg;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  req_dr;
    logic        mem_en, mem_we, mem_r;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, data;
    logic        ld_reg, done, err;
    logic [2:0]  dr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lc3b_mem_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ldreg(req_ldreg), .req_dr(req_dr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_r(mem_r),
        .data(data), .ld_reg(ld_reg), .dr(dr), .done(done), .err(err)
    );

    typedef struct {
        logic        we;
        logic        is_byte;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ldreg;
        logic [2:0]  dr;
        logic [15:0] rdata;
        int          delay;     // mem_r goes high in this mem_en cycle (0 = never)
        int          exp_en;    // expected number of mem_en cycles
        logic [1:0]  exp_be;
        logic [15:0] exp_maddr;
        logic [15:0] exp_mwdata;
        logic [15:0] exp_data;
        logic        exp_ldreg;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int en_cnt;
        int cyc;
        bit seen_done;
        en_cnt = 0;
        seen_done = 0;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", idx), 16'(req_ready), 16'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_byte  = v.is_byte;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_ldreg = v.ldreg;
        req_dr    = v.dr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 16'hFFFF;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            mem_r = 1'b0;
            mem_rdata = 16'h0F0F;
            if (cyc == 1)
                chk($sformatf("v%0d mem_en_first", idx), 16'(mem_en), 16'(v.exp_en > 0));
            if (mem_en) begin
                en_cnt++;
                chk($sformatf("v%0d mem_we", idx), 16'(mem_we), 16'(v.we));
                chk($sformatf("v%0d mem_be", idx), 16'(mem_be), 16'(v.exp_be));
                chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_maddr);
                chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_mwdata);
                if (en_cnt == v.delay) begin
                    mem_r = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (done) begin
                seen_done = 1;
                chk($sformatf("v%0d done_cycle", idx), 16'(cyc), 16'(v.exp_en + 1));
                chk($sformatf("v%0d err", idx), 16'(err), 16'(v.exp_err));
                chk($sformatf("v%0d ld_reg", idx), 16'(ld_reg), 16'(v.exp_ldreg));
                if (!v.exp_err) begin
                    chk($sformatf("v%0d data", idx), data, v.exp_data);
                    chk($sformatf("v%0d dr", idx), 16'(dr), 16'(v.dr));
                end
                break;
            end
        end
        if (!seen_done) begin
            checks++;
            failures++;
            $display("FAIL v%0d timeout: no done within 20 cycles", idx);
        end
        chk($sformatf("v%0d mem_en_count", idx), 16'(en_cnt), 16'(v.exp_en));
        @(negedge clk);
        chk($sformatf("v%0d ready_after", idx), 16'(req_ready), 16'd1);
        chk($sformatf("v%0d done_after", idx), 16'(done), 16'd0);
    endtask

    initial begin
        //          we byte addr      wdata     ldreg dr  rdata     dly en be     maddr     mwdata    data      ldr err
        vecs[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 3'd5, 16'hBEEF, 2, 2, 2'b11, 16'h3000, 16'h0000, 16'hBEEF, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h3001, 16'h0000, 1'b1, 3'd2, 16'h80AA, 1, 1, 2'b10, 16'h3000, 16'h0000, 16'hFF80, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 1'b1, 3'd4, 16'h80AA, 3, 3, 2'b01, 16'h3000, 16'h0000, 16'hFFAA, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h4001, 16'h1234, 1'b1, 3'd3, 16'h5555, 1, 1, 2'b10, 16'h4000, 16'h3434, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h3003, 16'h0000, 1'b1, 3'd1, 16'h1111, 0, 0, 2'b11, 16'h3002, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 16'h5000, 16'h0000, 1'b1, 3'd6, 16'h2222, 0, 4, 2'b11, 16'h5000, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 16'h6002, 16'hA5C3, 1'b0, 3'd1, 16'h3333, 1, 1, 2'b11, 16'h6002, 16'hA5C3, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'h2001, 16'h0000, 1'b0, 3'd7, 16'h7F11, 4, 4, 2'b10, 16'h2000, 16'h0000, 16'h007F, 1'b0, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; req_ldreg = 1'b0; req_dr = '0;
        mem_r = 1'b0; mem_rdata = 16'h0F0F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 16'(req_ready), 16'd1);
        chk("reset mem_en", 16'(mem_en), 16'd0);
        chk("reset done", 16'(done), 16'd0);
        chk("reset ld_reg", 16'(ld_reg), 16'd0);
        chk("reset data", data, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            if (i == 5) begin
                // late mem_r pulse after a timeout must not write the register file
                mem_r = 1'b1; mem_rdata = 16'hABCD;
                @(negedge clk);
                chk("late mem_r ld_reg", 16'(ld_reg), 16'd0);
                chk("late mem_r done", 16'(done), 16'd0);
                chk("late mem_r mem_en", 16'(mem_en), 16'd0);
                mem_r = 1'b0;
            end
        end

        // reset during the second ACCESS cycle aborts the access
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0;
        req_addr = 16'h7000; req_ldreg = 1'b1; req_dr = 3'd6;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort first access", 16'(mem_en), 16'd1);
        @(negedge clk);
        chk("abort second access", 16'(mem_en), 16'd1);
        rst = 1'b1;
        mem_r = 1'b1; mem_rdata = 16'h9999;
        @(negedge clk);
        rst = 1'b0;
        mem_r = 1'b0;
        chk("abort mem_en", 16'(mem_en), 16'd0);
        chk("abort req_ready", 16'(req_ready), 16'd1);
        chk("abort done", 16'(done), 16'd0);
        chk("abort ld_reg", 16'(ld_reg), 16'd0);
        @(negedge clk);
        chk("abort no late done", 16'(done), 16'd0);
        chk("abort no late ld_reg", 16'(ld_reg), 16'd0);
        run_vec(8, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

endmodule
